// File: rtl/apb_arb_pkg.sv
// Shared definitions for the two-requester APB arbiter: FSM states,
// owner identifiers and the default PREADY timeout.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } state_e;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

  localparam int DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/apb_rr_pick.sv
// Two-way round-robin pick. A lone requester always wins; on a tie the
// requester that was not served last wins. Purely combinational.
module apb_rr_pick
  import apb_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic gnt_valid,
  output logic gnt_id
);

  // Select the winner from the current requests and the previous owner
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = OWN_M0;
    if (req0 && req1) begin
      gnt_id = ~last_owner;
    end else if (req1) begin
      gnt_id = OWN_M1;
    end
  end

endmodule

// File: rtl/apb_arbiter_2m.sv
// Two-requester APB arbiter/sequencer. Grants the shared APB bus in IDLE
// with round-robin fairness, runs the SETUP/ACCESS sequence from registered
// outputs, and terminates a stalled ACCESS with an error after a timeout.
module apb_arbiter_2m
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TO_W           = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_write,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_done,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_write,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_done,
  output logic              m1_err,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              busy
);

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);

  state_e          state_q, state_d;
  logic            owner_q;
  logic            last_owner_q;
  logic [TO_W-1:0] to_cnt_q;

  logic            gnt_valid;
  logic            gnt_id;
  logic            grant;
  logic            fin;
  logic            to_hit;

  apb_rr_pick u_pick (
    .req0       (m0_req),
    .req1       (m1_req),
    .last_owner (last_owner_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // Next state plus grant / completion / timeout strobes
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    fin     = 1'b0;
    to_hit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d = SETUP;
          grant   = 1'b1;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // pready takes priority over a timeout landing in the same cycle
        if (pready) begin
          fin     = 1'b1;
          state_d = IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_LIM)) begin
          fin     = 1'b1;
          to_hit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, ownership history and ACCESS wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_M0;
      last_owner_q <= OWN_M1;
      to_cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q      <= gnt_id;
        last_owner_q <= gnt_id;
      end
      if (state_q == SETUP) begin
        to_cnt_q <= '0;
      end else if ((state_q == ACCESS) && !pready) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
    end
  end

  // Registered APB bus and requester responses
  always_ff @(posedge clk) begin
    if (rst) begin
      paddr    <= '0;
      pwdata   <= '0;
      pwrite   <= 1'b0;
      psel     <= 1'b0;
      penable  <= 1'b0;
      m0_rdata <= '0;
      m0_done  <= 1'b0;
      m0_err   <= 1'b0;
      m1_rdata <= '0;
      m1_done  <= 1'b0;
      m1_err   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      busy    <= (state_d != IDLE);
      if (grant) begin
        paddr   <= (gnt_id == OWN_M1) ? m1_addr  : m0_addr;
        pwdata  <= (gnt_id == OWN_M1) ? m1_wdata : m0_wdata;
        pwrite  <= (gnt_id == OWN_M1) ? m1_write : m0_write;
        psel    <= 1'b1;
        penable <= 1'b0;
      end
      if (state_q == SETUP) begin
        penable <= 1'b1;
      end
      if (fin) begin
        psel    <= 1'b0;
        penable <= 1'b0;
        if (owner_q == OWN_M0) begin
          m0_done <= 1'b1;
          m0_err  <= to_hit | pslverr;
          if (!pwrite) begin
            m0_rdata <= to_hit ? '0 : prdata;
          end
        end else begin
          m1_done <= 1'b1;
          m1_err  <= to_hit | pslverr;
          if (!pwrite) begin
            m1_rdata <= to_hit ? '0 : prdata;
          end
        end
      end
    end
  end

endmodule
